// File: rtl/decode_stage_pkg.sv
// Shared control encodings and the decoded control bundle for the decode stage.
// Opcodes, ALU/branch function codes, operand/writeback selects and load/store sizes.
package decode_stage_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [4:0] ALU_X    = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_AND  = 5'd3;
    localparam logic [4:0] ALU_OR   = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SLL  = 5'd6;
    localparam logic [4:0] ALU_SRL  = 5'd7;
    localparam logic [4:0] ALU_SRA  = 5'd8;
    localparam logic [4:0] ALU_SLT  = 5'd9;
    localparam logic [4:0] ALU_SLTU = 5'd10;
    localparam logic [4:0] BR_BEQ   = 5'd11;
    localparam logic [4:0] BR_BNE   = 5'd12;
    localparam logic [4:0] BR_BLT   = 5'd13;
    localparam logic [4:0] BR_BGE   = 5'd14;
    localparam logic [4:0] BR_BLTU  = 5'd15;
    localparam logic [4:0] BR_BGEU  = 5'd16;
    localparam logic [4:0] ALU_JALR = 5'd17;

    localparam logic [1:0] OP1_RS1 = 2'd0;
    localparam logic [1:0] OP1_PC  = 2'd1;
    localparam logic [1:0] OP1_X   = 2'd2;

    localparam logic [2:0] OP2_X   = 3'd0;
    localparam logic [2:0] OP2_RS2 = 3'd1;
    localparam logic [2:0] OP2_IMI = 3'd2;
    localparam logic [2:0] OP2_IMS = 3'd3;
    localparam logic [2:0] OP2_IMJ = 3'd4;
    localparam logic [2:0] OP2_IMU = 3'd5;

    localparam logic MEN_X = 1'b0;
    localparam logic MEN_S = 1'b1;
    localparam logic REN_X = 1'b0;
    localparam logic REN_S = 1'b1;

    localparam logic [1:0] WB_X   = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_MEM = 2'd2;
    localparam logic [1:0] WB_PC  = 2'd3;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LD  = 3'b011;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef struct packed {
        logic [4:0] exe_fun;
        logic [1:0] op1;
        logic [2:0] op2;
        logic       mem_wen;
        logic       rf_wen;
        logic [1:0] wb_sel;
        logic [2:0] mem_size;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_X = '{
        exe_fun:  ALU_X,
        op1:      OP1_X,
        op2:      OP2_X,
        mem_wen:  MEN_X,
        rf_wen:   REN_X,
        wb_sel:   WB_X,
        mem_size: 3'b000,
        illegal:  1'b0
    };

endpackage

// File: rtl/decode_logic.sv
// Purely combinational RV32I/RV64I base decoder: instruction word in,
// control bundle plus XLEN-wide sign-extended immediate out.
module decode_logic
    import decode_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int EN_SUBWORD = 1
) (
    input  logic [31:0]     i_inst,
    output ctrl_t           o_ctrl,
    output logic [XLEN-1:0] o_imm
);

    logic [6:0]         w_opc;
    logic [2:0]         w_f3;
    logic [6:0]         w_f7;
    logic signed [31:0] w_imm_i;
    logic signed [31:0] w_imm_s;
    logic signed [31:0] w_imm_b;
    logic signed [31:0] w_imm_u;
    logic signed [31:0] w_imm_j;
    logic signed [31:0] w_imm32;
    logic               w_bad;
    logic               w_sh_lo_ok;
    logic               w_sh_hi_ok;
    ctrl_t              w_ctrl;

    assign w_opc   = i_inst[6:0];
    assign w_f3    = i_inst[14:12];
    assign w_f7    = i_inst[31:25];
    assign w_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
    assign w_imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign w_imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign w_imm_u = {i_inst[31:12], 12'b0};
    assign w_imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

    // RV64 uses inst[25] as shamt[5], so only funct7[6:1] qualifies the shift
    assign w_sh_lo_ok = (XLEN == 64) ? (i_inst[31:26] == 6'b000000)
                                     : (w_f7 == 7'b0000000);
    assign w_sh_hi_ok = (XLEN == 64) ? (i_inst[31:26] == 6'b000000 || i_inst[31:26] == 6'b010000)
                                     : (w_f7 == 7'b0000000 || w_f7 == 7'b0100000);

    always_comb begin
        w_ctrl  = CTRL_X;
        w_imm32 = '0;
        w_bad   = 1'b0;
        case (w_opc)
            OPC_LUI: begin
                w_ctrl.exe_fun = ALU_ADD; w_ctrl.op1 = OP1_X;  w_ctrl.op2 = OP2_IMU;
                w_ctrl.rf_wen  = REN_S;   w_ctrl.wb_sel = WB_ALU; w_imm32 = w_imm_u;
            end
            OPC_AUIPC: begin
                w_ctrl.exe_fun = ALU_ADD; w_ctrl.op1 = OP1_PC; w_ctrl.op2 = OP2_IMU;
                w_ctrl.rf_wen  = REN_S;   w_ctrl.wb_sel = WB_ALU; w_imm32 = w_imm_u;
            end
            OPC_JAL: begin
                w_ctrl.exe_fun = ALU_ADD; w_ctrl.op1 = OP1_PC; w_ctrl.op2 = OP2_IMJ;
                w_ctrl.rf_wen  = REN_S;   w_ctrl.wb_sel = WB_PC; w_imm32 = w_imm_j;
            end
            OPC_JALR: begin
                w_ctrl.exe_fun = ALU_JALR; w_ctrl.op1 = OP1_RS1; w_ctrl.op2 = OP2_IMI;
                w_ctrl.rf_wen  = REN_S;    w_ctrl.wb_sel = WB_PC; w_imm32 = w_imm_i;
                w_bad = (w_f3 != 3'b000);
            end
            OPC_BRANCH: begin
                w_ctrl.op1 = OP1_RS1; w_ctrl.op2 = OP2_RS2; w_imm32 = w_imm_b;
                case (w_f3)
                    3'b000:  w_ctrl.exe_fun = BR_BEQ;
                    3'b001:  w_ctrl.exe_fun = BR_BNE;
                    3'b100:  w_ctrl.exe_fun = BR_BLT;
                    3'b101:  w_ctrl.exe_fun = BR_BGE;
                    3'b110:  w_ctrl.exe_fun = BR_BLTU;
                    3'b111:  w_ctrl.exe_fun = BR_BGEU;
                    default: w_bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                w_ctrl.exe_fun = ALU_ADD; w_ctrl.op1 = OP1_RS1; w_ctrl.op2 = OP2_IMI;
                w_ctrl.rf_wen  = REN_S;   w_ctrl.wb_sel = WB_MEM;
                w_ctrl.mem_size = w_f3;   w_imm32 = w_imm_i;
                w_bad = !((w_f3 inside {FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU})
                          || (w_f3 == FUNCT3_LD && XLEN == 64))
                        || (EN_SUBWORD == 0 && w_f3 != FUNCT3_LW);
            end
            OPC_STORE: begin
                w_ctrl.exe_fun = ALU_ADD; w_ctrl.op1 = OP1_RS1; w_ctrl.op2 = OP2_IMS;
                w_ctrl.mem_wen = MEN_S;   w_ctrl.mem_size = w_f3; w_imm32 = w_imm_s;
                w_bad = (w_f3 > FUNCT3_SW) || (EN_SUBWORD == 0 && w_f3 != FUNCT3_SW);
            end
            OPC_OPIMM: begin
                w_ctrl.op1 = OP1_RS1; w_ctrl.op2 = OP2_IMI;
                w_ctrl.rf_wen = REN_S; w_ctrl.wb_sel = WB_ALU; w_imm32 = w_imm_i;
                case (w_f3)
                    3'b000: w_ctrl.exe_fun = ALU_ADD;
                    3'b010: w_ctrl.exe_fun = ALU_SLT;
                    3'b011: w_ctrl.exe_fun = ALU_SLTU;
                    3'b100: w_ctrl.exe_fun = ALU_XOR;
                    3'b110: w_ctrl.exe_fun = ALU_OR;
                    3'b111: w_ctrl.exe_fun = ALU_AND;
                    3'b001: begin
                        w_ctrl.exe_fun = ALU_SLL;
                        w_bad = !w_sh_lo_ok;
                    end
                    default: begin
                        w_ctrl.exe_fun = i_inst[30] ? ALU_SRA : ALU_SRL;
                        w_bad = !w_sh_hi_ok;
                    end
                endcase
            end
            OPC_OP: begin
                w_ctrl.op1 = OP1_RS1; w_ctrl.op2 = OP2_RS2;
                w_ctrl.rf_wen = REN_S; w_ctrl.wb_sel = WB_ALU;
                case ({w_f7, w_f3})
                    {7'b0000000, 3'b000}: w_ctrl.exe_fun = ALU_ADD;
                    {7'b0100000, 3'b000}: w_ctrl.exe_fun = ALU_SUB;
                    {7'b0000000, 3'b001}: w_ctrl.exe_fun = ALU_SLL;
                    {7'b0000000, 3'b010}: w_ctrl.exe_fun = ALU_SLT;
                    {7'b0000000, 3'b011}: w_ctrl.exe_fun = ALU_SLTU;
                    {7'b0000000, 3'b100}: w_ctrl.exe_fun = ALU_XOR;
                    {7'b0000000, 3'b101}: w_ctrl.exe_fun = ALU_SRL;
                    {7'b0100000, 3'b101}: w_ctrl.exe_fun = ALU_SRA;
                    {7'b0000000, 3'b110}: w_ctrl.exe_fun = ALU_OR;
                    {7'b0000000, 3'b111}: w_ctrl.exe_fun = ALU_AND;
                    default:              w_bad = 1'b1;
                endcase
            end
            default: w_bad = 1'b1;
        endcase

        if (i_inst[1:0] != 2'b11)
            w_bad = 1'b1;
        // an illegal bundle still travels downstream so execute can trap on it
        if (w_bad) begin
            w_ctrl         = CTRL_X;
            w_ctrl.illegal = 1'b1;
            w_imm32        = '0;
        end
        if (i_inst[11:7] == 5'd0)
            w_ctrl.rf_wen = REN_X;
    end

    assign o_ctrl = w_ctrl;
    assign o_imm  = XLEN'(w_imm32);

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready handshake, one output register plus one
// skid entry holding the raw instruction, flush, and a single shared decoder.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int PC_W       = 32,
    parameter int EN_SUBWORD = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [PC_W-1:0] pc_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] pc_out,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      op1_addr,
    output logic [4:0]      op2_addr,
    output logic [4:0]      rd_addr,
    output logic [4:0]      exe_fun,
    output logic [1:0]      op1,
    output logic [2:0]      op2,
    output logic            mem_wen,
    output logic            rf_wen,
    output logic [1:0]      wb_sel,
    output logic [2:0]      mem_size,
    output logic            illegal
);

    logic            r_out_valid;
    logic            r_skid_full;
    logic [31:0]     r_skid_inst;
    logic [PC_W-1:0] r_skid_pc;
    ctrl_t           r_ctrl;
    logic [XLEN-1:0] r_imm;
    logic [PC_W-1:0] r_pc;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;

    logic            w_accept;
    logic            w_load_out;
    logic            w_load_data;
    logic [31:0]     w_src_inst;
    logic [PC_W-1:0] w_src_pc;
    ctrl_t           w_ctrl;
    logic [XLEN-1:0] w_imm;

    // in_ready depends only on state and flush, never on out_ready
    assign in_ready    = ~r_skid_full | flush;
    assign w_accept    = in_valid & in_ready;
    assign w_load_out  = ~r_out_valid | out_ready;
    assign w_load_data = ~flush & w_load_out & (r_skid_full | w_accept);
    assign w_src_inst  = r_skid_full ? r_skid_inst : inst;
    assign w_src_pc    = r_skid_full ? r_skid_pc   : pc_in;

    decode_logic #(
        .XLEN       (XLEN),
        .EN_SUBWORD (EN_SUBWORD)
    ) u_decode (
        .i_inst (w_src_inst),
        .o_ctrl (w_ctrl),
        .o_imm  (w_imm)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_skid_full <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_skid_full <= 1'b0;
        end else if (w_load_out) begin
            r_out_valid <= r_skid_full | w_accept;
            r_skid_full <= 1'b0;
        end else if (w_accept) begin
            r_skid_full <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl <= CTRL_X;
            r_imm  <= '0;
            r_pc   <= '0;
            r_rs1  <= '0;
            r_rs2  <= '0;
            r_rd   <= '0;
        end else if (w_load_data) begin
            r_ctrl <= w_ctrl;
            r_imm  <= w_imm;
            r_pc   <= w_src_pc;
            r_rs1  <= w_src_inst[19:15];
            r_rs2  <= w_src_inst[24:20];
            r_rd   <= w_src_inst[11:7];
        end
    end

    // skid keeps the raw word; it is decoded when it moves to the output register
    always_ff @(posedge clk) begin
        if (w_accept && !w_load_out) begin
            r_skid_inst <= inst;
            r_skid_pc   <= pc_in;
        end
    end

    assign out_valid = r_out_valid;
    assign pc_out    = r_pc;
    assign imm       = r_imm;
    assign op1_addr  = r_rs1;
    assign op2_addr  = r_rs2;
    assign rd_addr   = r_rd;
    assign exe_fun   = r_ctrl.exe_fun;
    assign op1       = r_ctrl.op1;
    assign op2       = r_ctrl.op2;
    assign mem_wen   = r_ctrl.mem_wen;
    assign rf_wen    = r_ctrl.rf_wen;
    assign wb_sel    = r_ctrl.wb_sel;
    assign mem_size  = r_ctrl.mem_size;
    assign illegal   = r_ctrl.illegal;

endmodule
